// File: rtl/pp_result_packer_if.sv
// Element-in / mask-word-out handshake bundle for pp_result_packer.
// The slave modport is the packer's view and the master modport is the producer/consumer side.
interface pp_result_packer_if #(
    parameter int NUM_SIZE  = 32,
    parameter int MASK_WORD = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 out;
    logic [NUM_SIZE-1:0]  out1;
    logic                 in_last;
    logic                 m_valid;
    logic                 m_ready;
    logic [MASK_WORD-1:0] m_data;
    logic                 m_last;

    modport slave (
        input  in_valid, out, out1, in_last, m_ready,
        output in_ready, m_valid, m_data, m_last
    );

    modport master (
        output in_valid, out, out1, in_last, m_ready,
        input  in_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/pp_result_packer.sv
// Packs per-element predicate bits into LSB-first mask words on a valid/ready stream.
// It also keeps per-column true/element counts and a masked sum, and pulses done once a column's last word is taken.
module pp_result_packer #(
    parameter int NUM_SIZE  = 32,
    parameter int MASK_WORD = 32,
    parameter int CNT_W     = 32,
    parameter int ACC_W     = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    pp_result_packer_if.slave bus,
    output logic [CNT_W-1:0] true_count_o,
    output logic [CNT_W-1:0] elem_count_o,
    output logic [ACC_W-1:0] masked_sum_o,
    output logic             done_o
);
    localparam int IDX_W = (MASK_WORD > 1) ? $clog2(MASK_WORD) : 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [MASK_WORD-1:0] pack_q, pack_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     runElem_q, runElem_d;
    logic [CNT_W-1:0]     runTrue_q, runTrue_d;
    logic [ACC_W-1:0]     runSum_q, runSum_d;
    logic                 mValid_q, mValid_d;
    logic [MASK_WORD-1:0] mData_q, mData_d;
    logic                 mLast_q, mLast_d;
    logic [CNT_W-1:0]     trueCount_q, trueCount_d;
    logic [CNT_W-1:0]     elemCount_q, elemCount_d;
    logic [ACC_W-1:0]     maskedSum_q, maskedSum_d;
    logic                 done_q, done_d;

    logic                 inReady;
    logic                 accept;
    logic                 wordEnd;
    logic [MASK_WORD-1:0] mergedWord;
    logic [CNT_W-1:0]     nextElem;
    logic [CNT_W-1:0]     nextTrue;
    logic [ACC_W-1:0]     nextSum;

    // The output register must be free (empty or draining) before a new element is taken,
    // so a completing element can never overwrite an unconsumed word.
    assign inReady = (state_q == RUN) && (!mValid_q || bus.m_ready);
    assign accept  = bus.in_valid && inReady;
    assign wordEnd = (idx_q == IDX_W'(MASK_WORD - 1)) || bus.in_last;

    always_comb begin
        state_d     = state_q;
        pack_d      = pack_q;
        idx_d       = idx_q;
        runElem_d   = runElem_q;
        runTrue_d   = runTrue_q;
        runSum_d    = runSum_q;
        mValid_d    = mValid_q;
        mData_d     = mData_q;
        mLast_d     = mLast_q;
        trueCount_d = trueCount_q;
        elemCount_d = elemCount_q;
        maskedSum_d = maskedSum_q;
        done_d      = 1'b0;

        mergedWord         = pack_q;
        mergedWord[idx_q]  = bus.out;

        nextElem = runElem_q + CNT_W'(1);
        nextTrue = runTrue_q + CNT_W'(bus.out);
        nextSum  = bus.out ? (runSum_q + ACC_W'(bus.out1)) : runSum_q;

        if (mValid_q && bus.m_ready) begin
            mValid_d = 1'b0;
        end

        if (accept) begin
            if (wordEnd) begin
                mData_d  = mergedWord;
                mLast_d  = bus.in_last;
                mValid_d = 1'b1;
                pack_d   = '0;
                idx_d    = '0;
            end else begin
                pack_d   = mergedWord;
                idx_d    = idx_q + IDX_W'(1);
            end

            if (bus.in_last) begin
                trueCount_d = nextTrue;
                elemCount_d = nextElem;
                maskedSum_d = nextSum;
                runElem_d   = '0;
                runTrue_d   = '0;
                runSum_d    = '0;
                state_d     = DRAIN;
            end else begin
                runElem_d   = nextElem;
                runTrue_d   = nextTrue;
                runSum_d    = nextSum;
            end
        end

        // In DRAIN the only word that can be pending is the column's last one.
        if ((state_q == DRAIN) && mValid_q && bus.m_ready && mLast_q) begin
            state_d = RUN;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pack_q      <= '0;
            idx_q       <= '0;
            runElem_q   <= '0;
            runTrue_q   <= '0;
            runSum_q    <= '0;
            mValid_q    <= 1'b0;
            mData_q     <= '0;
            mLast_q     <= 1'b0;
            trueCount_q <= '0;
            elemCount_q <= '0;
            maskedSum_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pack_q      <= pack_d;
            idx_q       <= idx_d;
            runElem_q   <= runElem_d;
            runTrue_q   <= runTrue_d;
            runSum_q    <= runSum_d;
            mValid_q    <= mValid_d;
            mData_q     <= mData_d;
            mLast_q     <= mLast_d;
            trueCount_q <= trueCount_d;
            elemCount_q <= elemCount_d;
            maskedSum_q <= maskedSum_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready = inReady;
    assign bus.m_valid  = mValid_q;
    assign bus.m_data   = mData_q;
    assign bus.m_last   = mLast_q;
    assign true_count_o = trueCount_q;
    assign elem_count_o = elemCount_q;
    assign masked_sum_o = maskedSum_q;
    assign done_o       = done_q;
endmodule

// File: doc/pp_result_packer.md
Name: pp_result_packer

Overview:
- Downstream stage of the per-element compute unit.
- Consumes one result per element: a 1-bit predicate (`out`) and a NUM_SIZE-bit value (`out1`).
- Packs predicate bits into MASK_WORD-bit mask words on a valid/ready output stream for DMA write-back.
- Accumulates per-column statistics (true count, element count, masked sum) and pulses `done` once a column is fully written out.

Parameters:
- NUM_SIZE, 32, width of numeric result `out1`.
- MASK_WORD, 32, predicate bits per packed mask word (≥2).
- CNT_W, 32, width of element/true counters.
- ACC_W, 48, width of masked-sum accumulator (≥ NUM_SIZE).

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  result element present.
- in_ready  out  1  packer accepts element this cycle.
- out  in  1  predicate result of element.
- out1  in  NUM_SIZE  numeric result of element (unsigned).
- in_last  in  1  element is last of column.
- m_valid  out  1  mask word valid.
- m_ready  in  1  downstream accepts mask word.
- m_data  out  MASK_WORD  packed predicate bits, element i at bit i (LSB-first).
- m_last  out  1  word is final word of column.
- true_count  out  CNT_W  predicate-true count of last completed column.
- elem_count  out  CNT_W  element count of last completed column.
- masked_sum  out  ACC_W  sum of out1 where out==1, last completed column.
- done  out  1  one-cycle pulse: column fully emitted.

Behaviour:
- Reset (reset==0, async): state RUN; pack register, bit index, running counters/sum cleared; m_valid=0, m_data=0, m_last=0, true_count=0, elem_count=0, masked_sum=0, done=0. A reset mid-column discards all partial data; no word or done is emitted for it.
- Accept = in_valid && in_ready.
- in_ready = (state==RUN) && (!m_valid || m_ready). This is a combinational path from m_ready, and it is intentional.
- Full throughput is one element per clock while downstream holds m_ready=1.
- On accept:
  - out is written to pack bit [idx], and idx increments.
  - Running elem count +1.
  - If out==1: running true count +1, and running sum += zero-extended out1.
  - Counters and sum wrap modulo 2^CNT_W and 2^ACC_W.
- Word completion: occurs when the accepted element has idx==MASK_WORD-1 or in_last==1.
  - Completed word (the new bit merged in) loads the output register in the same edge. Unfilled upper bits are 0.
  - m_last is set to in_last. Pack register and idx are cleared.
  - m_valid=1 on the following cycle (one-cycle latency from completing element to word visible).
- Output handshake: m_data and m_last are held stable while m_valid && !m_ready.
  - On m_valid && m_ready with no new word loading, m_valid drops to 0.
  - Simultaneous drain and load: the new word replaces the old one, and m_valid stays 1.
- Last element accepted:
  - true_count, elem_count and masked_sum load the final running values (including this element).
  - Running values clear. State goes to DRAIN, so in_ready=0.
- DRAIN: when m_valid && m_ready && m_last, go to RUN and assert done=1 for exactly the next cycle.
  - The next column's elements may be accepted in that same next cycle.
- Statistics outputs hold from the last-accept edge until the next column's last-accept.
- in_valid with in_ready=0: element is not consumed; upstream must hold it.
- in_last on a non-boundary element: short final word, zero-padded.
- in_last exactly at idx==MASK_WORD-1: full word with m_last=1; no extra empty word.
- A column of a single element is legal: one word, bit0=out.

Test Plan:
- MASK_WORD=8, m_ready=1, 8 elements with out=1,0,1,1,0,0,0,1, out1=1..8, last on 8th -> one word m_data=0x8D, m_last=1; true_count=4, elem_count=8, masked_sum=1+3+4+8=16; done one cycle after word handshake.
- MASK_WORD=8, 11 elements all out=1, out1=0xFFFFFFFF, last on 11th -> words 0xFF (m_last=0) then 0x07 (m_last=1); true_count=11, masked_sum=11*0xFFFFFFFF=0xAFFFFFFF5.
- Backpressure: m_ready=0 for 5 cycles after first word -> m_data stable, in_ready=0, no element lost; release -> stream resumes; final words identical to unstalled run.
- Single element out=0, out1=0x1234, last -> m_data=0x00, m_last=1; true_count=0, elem_count=1, masked_sum=0.
- Back-to-back columns: second column's first element is accepted in the done cycle -> stats switch only at second column's last-accept; no merged words.
- Assert reset low mid-column (after 3 elements, word pending) -> all outputs 0 asynchronously; after release a fresh 8-element column produces correct word/stats with no residue.
